// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accelerator control-register path: FSM states,
// AXI response codes, register offsets and instruction opcodes.
package acc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  localparam int unsigned REG_CTRL0 = 32'h0;
  localparam int unsigned REG_CTRL1 = 32'h4;
  localparam int unsigned REG_CTRL2 = 32'h8;

  localparam int unsigned INST_COMPUTE    = 87;
  localparam int unsigned INST_LOADIFMAPS = 88;

endpackage

// File: rtl/axil_cfg_master.sv
// AXI4-Lite initiator: one command in, one single-beat write or read out,
// slave response returned on a valid/ready port. Sticky stall flag on slow phases.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a command
// ST_WR      | AW and W presented; each drops after its own handshake
// ST_WR_RESP | BREADY high, waiting for BVALID
// ST_RD_ADDR | ARVALID high, waiting for ARREADY
// ST_RD_DATA | RREADY high, waiting for RVALID
// ST_RSP     | rsp_valid high, held stable until rsp_ready
module axil_cfg_master
  import acc_ctrl_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int STALL_CYCLES       = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [1:0]                      rsp_resp,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                            busy,
  output logic                            stall_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int DW  = C_M_AXI_DATA_WIDTH;
  localparam int SW  = C_M_AXI_DATA_WIDTH / 8;
  localparam int SCW = $clog2(STALL_CYCLES + 1);
  localparam logic [SCW-1:0] STALL_MAX = SCW'(STALL_CYCLES);

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [SW-1:0]  wstrb_q, wstrb_d;
  logic           aw_done_q, aw_done_d;
  logic           w_done_q, w_done_d;
  logic           awvalid_q, awvalid_d;
  logic           wvalid_q, wvalid_d;
  logic           bready_q, bready_d;
  logic           arvalid_q, arvalid_d;
  logic           rready_q, rready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_write_q, rsp_write_d;
  logic [1:0]     rsp_resp_q, rsp_resp_d;
  logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
  logic           stall_err_q, stall_err_d;

  // Next-state, command/response capture and registered AXI handshake signals.
  // Valids/readies are derived from state_d so they change on the same edge as the state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          rsp_write_d = cmd_write;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          state_d     = cmd_write ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_WR: begin
        if (awvalid_q && M_AXI_AWREADY) aw_done_d = 1'b1;
        if (wvalid_q && M_AXI_WREADY)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)      state_d   = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (bready_q && M_AXI_BVALID) begin
          rsp_resp_d  = M_AXI_BRESP;
          rsp_rdata_d = '0;
          state_d     = ST_RSP;
        end
      end
      ST_RD_ADDR: begin
        if (arvalid_q && M_AXI_ARREADY) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (rready_q && M_AXI_RVALID) begin
          rsp_resp_d  = M_AXI_RRESP;
          rsp_rdata_d = M_AXI_RDATA;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // AW/W/AR rise one cycle after entering their state, keyed off state_q.
    awvalid_d   = (state_q == ST_WR) && !aw_done_d;
    wvalid_d    = (state_q == ST_WR) && !w_done_d;
    arvalid_d   = (state_q == ST_RD_ADDR) && (state_d == ST_RD_ADDR);
    bready_d    = (state_d == ST_WR_RESP);
    rready_d    = (state_d == ST_RD_DATA);
    rsp_valid_d = (state_d == ST_RSP);
  end

  // Per-phase wait counter; restarts on every state change and saturates at the limit.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_d != state_q) begin
      stall_cnt_d = '0;
    end else if ((state_q inside {ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA}) &&
                 (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + SCW'(1);
    end
    stall_err_d = stall_err_q || (stall_cnt_d == STALL_MAX);
  end

  // State and output registers with synchronous reset; reset abandons any open transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= '0;
      rsp_rdata_q <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign stall_err     = stall_err_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench for axil_cfg_master with a small delay-programmable AXI4-Lite slave.
module tb_axil_cfg_master;
  import acc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        stall_err;
  logic [3:0]  M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY = 1'b0;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00;
  logic        M_AXI_BVALID = 1'b0;
  logic        M_AXI_BREADY;
  logic [3:0]  M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = 2'b00;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;

  axil_cfg_master #(
    .C_M_AXI_ADDR_WIDTH(4),
    .C_M_AXI_DATA_WIDTH(32),
    .STALL_CYCLES(256)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .busy(busy), .stall_err(stall_err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // slave knobs and observations
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
  logic [31:0] rdata_val = '0;
  int          b_hs_cnt = 0, r_hs_cnt = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  logic        aw_got = 0, w_got = 0, ar_got = 0;
  logic        p_awv = 0, p_wv = 0, p_arv = 0, p_bready = 0, p_rready = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Slave: evaluated on falling edges; valid/ready are stable from here to the next rising edge,
  // so a handshake at that rising edge is visible here as (previous valid && current ready).
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
        M_AXI_BVALID = 0; M_AXI_RVALID = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
      end else begin
        if (p_awv && M_AXI_AWREADY) aw_got = 1;
        if (p_wv && M_AXI_WREADY)   w_got  = 1;
        if (p_arv && M_AXI_ARREADY) ar_got = 1;
        if (M_AXI_BVALID && p_bready) begin
          M_AXI_BVALID = 0; b_hs_cnt++; aw_got = 0; w_got = 0; b_cnt = 0;
        end
        if (M_AXI_RVALID && p_rready) begin
          M_AXI_RVALID = 0; r_hs_cnt++; ar_got = 0; r_cnt = 0;
        end
        if (M_AXI_AWVALID && !aw_got) begin M_AXI_AWREADY = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin M_AXI_AWREADY = 0; aw_cnt = 0; end
        if (M_AXI_WVALID && !w_got) begin M_AXI_WREADY = (w_cnt >= w_delay); w_cnt++; end
        else begin M_AXI_WREADY = 0; w_cnt = 0; end
        if (M_AXI_ARVALID && !ar_got) begin M_AXI_ARREADY = (ar_cnt >= ar_delay); ar_cnt++; end
        else begin M_AXI_ARREADY = 0; ar_cnt = 0; end
        if (aw_got && w_got && !M_AXI_BVALID) begin
          if (b_cnt >= b_delay) M_AXI_BVALID = 1; else b_cnt++;
        end
        if (ar_got && !M_AXI_RVALID) begin
          if (r_cnt >= r_delay) M_AXI_RVALID = 1; else r_cnt++;
        end
        M_AXI_BRESP = bresp_val;
        M_AXI_RRESP = rresp_val;
        M_AXI_RDATA = rdata_val;
        p_awv = M_AXI_AWVALID; p_wv = M_AXI_WVALID; p_arv = M_AXI_ARVALID;
        p_bready = M_AXI_BREADY; p_rready = M_AXI_RREADY;
      end
    end
  end

  // Returns #1 after the rising edge on which the command handshake happened.
  task automatic issue(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    @(negedge clk);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    check("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int max_cyc);
    logic seen;
    seen = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    check("rsp_arrive", seen, 1);
  endtask

  task automatic consume();
    @(negedge clk);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    check("idle_after_rsp", cmd_ready, 1);
    check("busy_after_rsp", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    logic any_rsp;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", M_AXI_AWVALID, 0);
    check("rst_wvalid", M_AXI_WVALID, 0);
    check("rst_arvalid", M_AXI_ARVALID, 0);
    check("rst_bready", M_AXI_BREADY, 0);
    check("rst_rready", M_AXI_RREADY, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_stall_err", stall_err, 0);
    check("rst_awaddr", M_AXI_AWADDR, 0);
    check("rst_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst = 0;

    // T1: zero-wait write 0x8 <- 0x10, edge-by-edge timeline
    issue(1'b1, 4'(REG_CTRL2), 32'h10, 4'hF);
    check("t1_e0_awvalid", M_AXI_AWVALID, 0);
    check("t1_e0_busy", busy, 1);
    @(posedge clk); #1;
    check("t1_e1_awvalid", M_AXI_AWVALID, 1);
    check("t1_e1_wvalid", M_AXI_WVALID, 1);
    check("t1_e1_awaddr", M_AXI_AWADDR, 4'h8);
    check("t1_e1_wdata", M_AXI_WDATA, 32'h10);
    check("t1_e1_wstrb", M_AXI_WSTRB, 4'hF);
    check("t1_e1_awprot", M_AXI_AWPROT, 3'b000);
    check("t1_e1_bready", M_AXI_BREADY, 0);
    @(posedge clk); #1;
    check("t1_e2_awvalid", M_AXI_AWVALID, 0);
    check("t1_e2_wvalid", M_AXI_WVALID, 0);
    check("t1_e2_bready", M_AXI_BREADY, 1);
    check("t1_e2_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    check("t1_e3_rsp_valid", rsp_valid, 1);
    check("t1_e3_bready", M_AXI_BREADY, 0);
    check("t1_rsp_resp", rsp_resp, AXI_RESP_OKAY);
    check("t1_rsp_write", rsp_write, 1);
    check("t1_rsp_rdata", rsp_rdata, 0);
    check("t1_cmd_ready", cmd_ready, 0);
    consume();

    // T2: write 0x0 <- 0x00102157, AWREADY 3 cycles ahead of WREADY
    aw_delay = 0; w_delay = 3;
    b0 = b_hs_cnt;
    issue(1'b1, 4'(REG_CTRL0), 32'h0010_2157, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t2_aw_dropped", M_AXI_AWVALID, 0);
    check("t2_w_held", M_AXI_WVALID, 1);
    check("t2_no_bready_yet", M_AXI_BREADY, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t2_w_held_late", M_AXI_WVALID, 1);
    check("t2_aw_still_low", M_AXI_AWVALID, 0);
    wait_rsp(20);
    check("t2_b_count", b_hs_cnt - b0, 1);
    check("t2_rsp_resp", rsp_resp, AXI_RESP_OKAY);
    check("t2_rsp_write", rsp_write, 1);
    consume();
    w_delay = 0;

    // T3: read 0x4 returning 0x0000000C with a 2-cycle RVALID delay
    r_delay = 2; rdata_val = 32'h0000_000C;
    issue(1'b0, 4'(REG_CTRL1), 32'hDEAD_BEEF, 4'h0);
    @(posedge clk); #1;
    check("t3_arvalid", M_AXI_ARVALID, 1);
    check("t3_araddr", M_AXI_ARADDR, 4'h4);
    check("t3_no_awvalid", M_AXI_AWVALID, 0);
    wait_rsp(20);
    check("t3_rsp_rdata", rsp_rdata, 32'h0000_000C);
    check("t3_rsp_write", rsp_write, 0);
    check("t3_rsp_resp", rsp_resp, AXI_RESP_OKAY);
    consume();
    r_delay = 0;

    // T4: SLVERR write response, response held 5 cycles
    bresp_val = AXI_RESP_SLVERR;
    issue(1'b1, 4'(REG_CTRL1), 32'h0000_0003, 4'h1);
    wait_rsp(20);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_resp", rsp_resp, AXI_RESP_SLVERR);
      check("t4_hold_cmd_ready", cmd_ready, 0);
    end
    check("t4_stall_clear", stall_err, 0);
    consume();
    bresp_val = AXI_RESP_OKAY;

    // T5: AWREADY held off 300 cycles; stall_err sets at cycle 256, transaction still completes
    aw_delay = 300;
    issue(1'b1, 4'(REG_CTRL2), 32'h0000_0020, 4'hF);
    repeat (255) @(posedge clk);
    #1;
    check("t5_stall_before", stall_err, 0);
    @(posedge clk); #1;
    check("t5_stall_at", stall_err, 1);
    check("t5_awvalid_held", M_AXI_AWVALID, 1);
    wait_rsp(100);
    check("t5_rsp_resp", rsp_resp, AXI_RESP_OKAY);
    consume();
    check("t5_stall_sticky", stall_err, 1);
    aw_delay = 0;

    // T6: reset while in WR_RESP, then a normal read
    b_delay = 5;
    issue(1'b1, 4'(REG_CTRL0), 32'h0000_0058, 4'hF);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = M_AXI_BREADY;
    end
    check("t6_reach_wr_resp", seen, 1);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check("t6_bready", M_AXI_BREADY, 0);
    check("t6_awvalid", M_AXI_AWVALID, 0);
    check("t6_wvalid", M_AXI_WVALID, 0);
    check("t6_arvalid", M_AXI_ARVALID, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_stall_cleared", stall_err, 0);
    @(negedge clk);
    rst = 0;
    b_delay = 0;
    any_rsp = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      any_rsp = any_rsp | rsp_valid;
    end
    check("t6_no_rsp", any_rsp, 0);
    check("t6_idle", cmd_ready, 1);
    rdata_val = 32'h0000_0057;
    issue(1'b0, 4'(REG_CTRL0), 32'h0, 4'h0);
    wait_rsp(20);
    check("t6_read_rdata", rsp_rdata, 32'h0000_0057);
    check("t6_read_write", rsp_write, 0);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
